// File: rtl/ex_result_stage.sv
// ex_result_stage
//   EX->MEM pipeline stage that sits behind the divide unit and the other
//   ALU units. A 2-entry skid buffer (main + skid) holds the result, its
//   destination register and its flags. The buffer hands them to the
//   MEM/writeback side over a valid/ready handshake. When an entry with
//   flag_we=1 leaves the stage, its flags are committed to the
//   architectural flag register flags_q.
//
// Configuration macro: ZERO_NORMALISE_EN
//   Defined   : on accept, zero = (in_result[MAG_W-1:0] == 0). When zero,
//               the sign bit (in_result[MAG_W]) and neg are cleared, so -0
//               is stored as +0.
//   Undefined : the result and flags are stored unmodified.
//
// Handshake: a transfer happens on a rising clk edge when valid && ready
//   are both high on that side. The upstream side holds in_* stable while
//   in_ready is low. Head fields (out_*) stay stable while
//   out_valid && !out_ready. in_ready and out_valid are registers, so no
//   path runs from in_* or out_ready to either of them.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   flush               drop all buffered entries on the next edge
//   in_valid/in_ready   upstream handshake
//   in_result, in_rd    unit result (sign-magnitude), destination register
//   in_flag_we          entry writes flags_q when it leaves the stage
//   in_cout/zero/overflow/neg   unit flags
//   out_valid/out_ready downstream handshake
//   out_result, out_rd  head result and destination
//   out_flags           head flags {neg,zero,cout,overflow}
//   flags_q             architectural flags {neg,zero,cout,overflow}
//   state_dbg           entry count state: 0=EMPTY, 1=ONE, 2=FULL
module ex_result_stage #(
  parameter int N     = 32,
  parameter int MAG_W = 15,
  parameter int RD_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_result,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_flag_we,
  input  logic            in_cout,
  input  logic            in_zero,
  input  logic            in_overflow,
  input  logic            in_neg,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_result,
  output logic [RD_W-1:0] out_rd,
  output logic [3:0]      out_flags,
  output logic [3:0]      flags_q,
  output logic [1:0]      state_dbg
);

`ifdef ZERO_NORMALISE_EN
  localparam bit NORM_EN = 1'b1;
`else
  localparam bit NORM_EN = 1'b0;
`endif

  // Entry layout: {flag_we, neg, zero, cout, overflow, rd, result}
  localparam int EW = 1 + 4 + RD_W + N;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state;
  logic [EW-1:0] main_q;
  logic [EW-1:0] skid_q;
  logic [EW-1:0] in_ent;
  logic [N-1:0]  n_result;
  logic          n_zero;
  logic          n_neg;
  logic          acc;
  logic          pop;
  logic          main_we;

  // The divider derives zero from the dividend. Recompute it from the
  // magnitude so that a zero quotient is flagged correctly and has no sign.
  always_comb begin
    n_result = in_result;
    n_zero   = in_zero;
    n_neg    = in_neg;
    if (NORM_EN) begin
      n_zero = (in_result[MAG_W-1:0] == '0);
      if (n_zero) begin
        n_result[MAG_W] = 1'b0;
        n_neg           = 1'b0;
      end
    end
  end

  assign in_ent = {in_flag_we, n_neg, n_zero, in_cout, in_overflow, in_rd, n_result};

  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;

  assign out_result = main_q[N-1:0];
  assign out_rd     = main_q[N+RD_W-1:N];
  assign out_flags  = main_q[N+RD_W+3:N+RD_W];
  assign main_we    = main_q[EW-1];
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      flags_q   <= 4'b0000;
    end else begin
      // The head still leaves on a flush edge, so its flags still commit.
      if (pop && main_we) flags_q <= out_flags;

      if (flush) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (acc) begin
              main_q    <= in_ent;
              state     <= ONE;
              out_valid <= 1'b1;
            end
          end
          ONE: begin
            if (acc && pop) begin
              main_q <= in_ent;
            end else if (acc) begin
              skid_q   <= in_ent;
              state    <= FULL;
              in_ready <= 1'b0;
            end else if (pop) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
          FULL: begin
            // in_ready is low here, so only a pop can happen.
            if (pop) begin
              main_q   <= skid_q;
              state    <= ONE;
              in_ready <= 1'b1;
            end
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_result_stage.sv
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic [3:0]  in_rd = '0;
  logic        in_flag_we = 1'b0;
  logic        in_cout = 1'b0;
  logic        in_zero = 1'b0;
  logic        in_overflow = 1'b0;
  logic        in_neg = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic [3:0]  out_flags;
  logic [3:0]  flags_q;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad = 0;

  // Reference model: FIFO of {we, flags[3:0], rd[3:0], result[31:0]}
  logic [40:0] exp_q[$];
  logic [3:0]  mflags = 4'b0000;
  logic [3:0]  saved_flags;

  ex_result_stage #(.N(32), .MAG_W(15), .RD_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rd(in_rd), .in_flag_we(in_flag_we),
    .in_cout(in_cout), .in_zero(in_zero), .in_overflow(in_overflow), .in_neg(in_neg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_flags(out_flags),
    .flags_q(flags_q), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entry as the stage should hold it. fl = {neg,zero,cout,ov}
  function automatic logic [40:0] mk(input logic we, input logic [3:0] fl,
                                     input logic [3:0] rd, input logic [31:0] res);
    logic [31:0] r;
    logic [3:0]  f;
    r = res;
    f = fl;
`ifdef ZERO_NORMALISE_EN
    if (r % 32768 == 0) begin
      if (r % 65536 >= 32768) r = r - 32768;
      f[3] = 1'b0;
      f[2] = 1'b1;
    end else begin
      f[2] = 1'b0;
    end
`endif
    return {we, f, rd, r};
  endfunction

  task automatic check_model();
    logic [40:0] h;
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
    chk("flags_q", {28'd0, flags_q}, {28'd0, mflags});
    chk("state", {30'd0, state_dbg}, exp_q.size());
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("out_result", out_result, h[31:0]);
      chk("out_rd", {28'd0, out_rd}, {28'd0, h[35:32]});
      chk("out_flags", {28'd0, out_flags}, {28'd0, h[39:36]});
    end
  endtask

  // One cycle: drive at negedge, check, clock, update model, back to negedge.
  task automatic step(input logic v, input logic [31:0] res, input logic [3:0] rd,
                      input logic we, input logic [3:0] fl, input logic ordy,
                      input logic fsh);
    logic [40:0] h;
    bit acc, pop;
    in_valid    = v;
    in_result   = res;
    in_rd       = rd;
    in_flag_we  = we;
    in_neg      = fl[3];
    in_zero     = fl[2];
    in_cout     = fl[1];
    in_overflow = fl[0];
    out_ready   = ordy;
    flush       = fsh;
    check_model();
    @(posedge clk);
    acc = v && (exp_q.size() < 2) && !fsh;
    pop = (exp_q.size() > 0) && ordy;
    if (pop) begin
      h = exp_q.pop_front();
      if (h[40]) mflags = h[39:36];
    end
    if (fsh) exp_q.delete();
    else if (acc) exp_q.push_back(mk(we, fl, rd, res));
    @(negedge clk);
  endtask

  initial begin
    // reset / idle
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", {28'd0, out_rd}, 32'd0);
    chk("rst_out_flags", {28'd0, out_flags}, 32'd0);
    chk("rst_flags_q", {28'd0, flags_q}, 32'd0);
    rst = 1'b0;
    step(0, 0, 0, 0, 4'b0000, 0, 0);
    chk("idle_flags_q", {28'd0, flags_q}, 32'd0);

    // single push then back-to-back pushes with out_ready=1
    step(1, 32'h3, 4'd1, 1, 4'b0000, 1, 0);
    chk("push_out_valid", {31'd0, out_valid}, 32'd1);
    chk("push_out_result", out_result, 32'h3);
    for (int i = 0; i < 5; i++) step(1, 32'h100 + i, 4'(i), 1, 4'(i), 1, 0);
    step(0, 0, 0, 0, 4'b0000, 1, 0);
    step(0, 0, 0, 0, 4'b0000, 1, 0);

    // fill with out_ready=0, then drain in order
    step(1, 32'h11, 4'd2, 0, 4'b0000, 0, 0);
    step(1, 32'h22, 4'd3, 0, 4'b0000, 0, 0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head", out_result, 32'h11);
    step(1, 32'h33, 4'd4, 0, 4'b0000, 0, 0);
    chk("held_head", out_result, 32'h11);
    step(0, 0, 0, 0, 4'b0000, 1, 0);
    chk("drain_head", out_result, 32'h22);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
    step(0, 0, 0, 0, 4'b0000, 1, 0);
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // accept + pop in ONE
    step(1, 32'h44, 4'd5, 0, 4'b0000, 1, 0);
    step(1, 32'h55, 4'd6, 0, 4'b0000, 1, 0);
    chk("accpop_state", {30'd0, state_dbg}, 32'd1);
    chk("accpop_head", out_result, 32'h55);
    step(0, 0, 0, 0, 4'b0000, 1, 0);

    // flush while FULL, with in_valid high
    step(1, 32'hA1, 4'd7, 1, 4'b1010, 0, 0);
    step(1, 32'hA2, 4'd8, 1, 4'b0011, 0, 0);
    saved_flags = flags_q;
    step(1, 32'hA3, 4'd9, 1, 4'b1111, 0, 1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_flags_q", {28'd0, flags_q}, {28'd0, saved_flags});
    // flush on a popping edge still commits the head's flags
    step(1, 32'hB1, 4'd1, 1, 4'b1011, 0, 0);
    step(1, 32'hB2, 4'd2, 1, 4'b0001, 1, 1);
    chk("flush_commit", {28'd0, flags_q}, 32'hB);

    // -0 normalisation
    step(1, 32'h8000, 4'd3, 1, 4'b1000, 0, 0);
`ifdef ZERO_NORMALISE_EN
    chk("norm_result", out_result, 32'h0);
    chk("norm_flags", {28'd0, out_flags}, 32'h4);
    step(0, 0, 0, 0, 4'b0000, 1, 0);
    chk("norm_flags_q", {28'd0, flags_q}, 32'h4);
`else
    chk("raw_result", out_result, 32'h8000);
    chk("raw_flags", {28'd0, out_flags}, 32'h8);
    step(0, 0, 0, 0, 4'b0000, 1, 0);
    chk("raw_flags_q", {28'd0, flags_q}, 32'h8);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r = r & 32'hFFFF_8000;
      step($urandom_range(0, 3) != 0, r, 4'($urandom), 1'($urandom),
           4'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
    end

    // async reset mid-operation
    step(1, 32'h77, 4'd4, 1, 4'b1111, 0, 0);
    step(1, 32'h78, 4'd5, 1, 4'b1111, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_flags_q", {28'd0, flags_q}, 32'd0);
    chk("arst_out_result", out_result, 32'd0);
    exp_q.delete();
    mflags = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0, 4'b0000, 1, 0);
    step(0, 0, 0, 0, 4'b0000, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
